// File: rtl/prog_delay_if.sv
// Signal bundle for prog_delay: the producer drives the control and input side,
// and the delay line drives the delayed word and its status.
interface prog_delay_if #(
  parameter int data_size = 16,
  parameter int size      = 1,
  parameter int max_cycle = 8
);
  localparam int DW = $clog2(max_cycle + 1);
  localparam int BW = data_size * size;

  // Valid-only qualification, no back-pressure: a word transfers on every edge where
  // en=1, load=0 and valid_in=1. valid_out marks bus_out as carrying a real word
  // that cycle. There is no ready signal, so the consumer must accept every valid word.
  logic          en;
  logic          load;
  logic [DW-1:0] delay_sel;
  logic [BW-1:0] bus_in;
  logic          valid_in;
  logic [BW-1:0] bus_out;
  logic          valid_out;
  logic [DW-1:0] cur_delay;
  logic [DW-1:0] count;

  modport master (
    output en, load, delay_sel, bus_in, valid_in,
    input  bus_out, valid_out, cur_delay, count
  );

  modport slave (
    input  en, load, delay_sel, bus_in, valid_in,
    output bus_out, valid_out, cur_delay, count
  );
endinterface

// File: rtl/prog_delay.sv
// Programmable delay line: max_cycle physical stages, output tapped at stage cur_delay-1.
// A load flushes all in-flight words and selects a new delay.
module prog_delay #(
  parameter int data_size     = 16,
  parameter int size          = 1,
  parameter int max_cycle     = 8,
  parameter int default_cycle = 1
) (
  input  logic         clk,
  input  logic         reset,
  prog_delay_if.slave  pd
);
  localparam int DW = $clog2(max_cycle + 1);
  localparam int BW = data_size * size;
  localparam int IW = (max_cycle > 1) ? $clog2(max_cycle) : 1;
  localparam logic [DW-1:0] ONE   = DW'(1);
  localparam logic [DW-1:0] MAX_D = DW'(max_cycle);
  localparam logic [DW-1:0] DEF_D = DW'(default_cycle);

  logic [BW-1:0]        data_q [max_cycle];
  logic [BW-1:0]        data_d [max_cycle];
  logic [max_cycle-1:0] vld_q, vld_d;
  logic [DW-1:0]        cur_delay_q, cur_delay_d;
  logic [DW-1:0]        count_q, count_d;
  logic [DW-1:0]        sel_clamped;
  logic [IW-1:0]        out_idx;

  assign out_idx = IW'(cur_delay_q - ONE);

  always_comb begin
    sel_clamped = pd.delay_sel;
    if (pd.delay_sel == '0) begin
      sel_clamped = ONE;
    end else if (pd.delay_sel > MAX_D) begin
      sel_clamped = MAX_D;
    end
  end

  always_comb begin
    vld_d       = vld_q;
    data_d      = data_q;
    cur_delay_d = cur_delay_q;
    count_d     = count_q;
    if (pd.load) begin
      // Only the valid bits are flushed; stale data is harmless once unqualified.
      vld_d       = '0;
      count_d     = '0;
      cur_delay_d = sel_clamped;
    end else if (pd.en) begin
      vld_d[0]  = pd.valid_in;
      data_d[0] = pd.bus_in;
      for (int k = 1; k < max_cycle; k++) begin
        vld_d[k]  = vld_q[k-1];
        data_d[k] = data_q[k-1];
      end
      case ({pd.valid_in, vld_q[out_idx]})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q       <= '0;
      cur_delay_q <= DEF_D;
      count_q     <= '0;
      for (int k = 0; k < max_cycle; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      vld_q       <= vld_d;
      cur_delay_q <= cur_delay_d;
      count_q     <= count_d;
      for (int k = 0; k < max_cycle; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign pd.bus_out   = data_q[out_idx];
  assign pd.valid_out = vld_q[out_idx];
  assign pd.cur_delay = cur_delay_q;
  assign pd.count     = count_q;
endmodule

// File: tb/tb_prog_delay.sv
// Directed bench for prog_delay: default 16-bit line plus a 4x8-bit packed instance.
module tb_prog_delay;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  prog_delay_if #(.data_size(16), .size(1), .max_cycle(8)) if0 ();
  prog_delay_if #(.data_size(8),  .size(4), .max_cycle(8)) if1 ();

  prog_delay #(.data_size(16), .size(1), .max_cycle(8), .default_cycle(1)) dut0 (
    .clk   (clk),
    .reset (reset),
    .pd    (if0.slave)
  );

  prog_delay #(.data_size(8), .size(4), .max_cycle(8), .default_cycle(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .pd    (if1.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic en, input logic load, input logic [3:0] sel,
                        input logic [15:0] data, input logic vin);
    if0.en        = en;
    if0.load      = load;
    if0.delay_sel = sel;
    if0.bus_in    = data;
    if0.valid_in  = vin;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s;
    int w;
    int ecount;
    logic exp_v;
    logic [31:0] word1 [$];

    reset = 1'b1;
    drive0(1'b1, 1'b0, 4'd0, 16'hFFFF, 1'b1);
    if1.en = 1'b0; if1.load = 1'b0; if1.delay_sel = '0; if1.bus_in = '0; if1.valid_in = 1'b0;
    tick();
    check("rst_bus_out",   64'(if0.bus_out),   64'h0);
    check("rst_valid_out", 64'(if0.valid_out), 64'h0);
    check("rst_count",     64'(if0.count),     64'h0);
    check("rst_cur_delay", 64'(if0.cur_delay), 64'h1);
    reset = 1'b0;

    // Delay 1: each word is visible right after its capture edge.
    for (int i = 1; i <= 16; i++) begin
      drive0(1'b1, 1'b0, 4'd0, 16'(i), 1'b1);
      tick();
      check("d1_bus_out",   64'(if0.bus_out),   64'(i));
      check("d1_valid_out", 64'(if0.valid_out), 64'h1);
      check("d1_count",     64'(if0.count),     64'h1);
    end
    drive0(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    tick();
    check("d1_drain_valid", 64'(if0.valid_out), 64'h0);
    check("d1_drain_count", 64'(if0.count),     64'h0);

    // Delay 5 stream of ten words with a 3-cycle stall in the middle.
    drive0(1'b1, 1'b1, 4'd5, 16'h0, 1'b0);
    tick();
    check("ld5_cur_delay", 64'(if0.cur_delay), 64'h5);
    check("ld5_valid",     64'(if0.valid_out), 64'h0);
    check("ld5_count",     64'(if0.count),     64'h0);
    s = 0;
    w = 0;
    for (int c = 0; c < 20; c++) begin
      if (c >= 6 && c <= 8) begin
        drive0(1'b0, 1'b0, 4'd0, 16'hDEAD, 1'b1);
      end else begin
        if (w < 10) begin
          drive0(1'b1, 1'b0, 4'd0, 16'(16'hA000 + w), 1'b1);
          w++;
        end else begin
          drive0(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
        end
        s++;
      end
      tick();
      exp_v  = (s - 4 >= 1) && (s - 4 <= 10);
      ecount = 0;
      for (int t = s - 4; t <= s; t++) begin
        if (t >= 1 && t <= 10) ecount++;
      end
      check("d5_valid_out", 64'(if0.valid_out), 64'(exp_v));
      if (exp_v) check("d5_bus_out", 64'(if0.bus_out), 64'(16'hA000 + (s - 5)));
      check("d5_count", 64'(if0.count), 64'(ecount));
    end

    // Load while words are in flight, issued with en=0, delay_sel=0 clamps to 1.
    for (int i = 0; i < 3; i++) begin
      drive0(1'b1, 1'b0, 4'd0, 16'(16'hB000 + i), 1'b1);
      tick();
    end
    drive0(1'b0, 1'b1, 4'd0, 16'hCCCC, 1'b1);
    tick();
    check("ld0_cur_delay", 64'(if0.cur_delay), 64'h1);
    check("ld0_valid",     64'(if0.valid_out), 64'h0);
    check("ld0_count",     64'(if0.count),     64'h0);
    drive0(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
    tick();
    check("ld0_post_valid", 64'(if0.valid_out), 64'h0);

    // delay_sel=12 clamps to 8; a lone word shows at the 8th shift then leaves.
    drive0(1'b1, 1'b1, 4'd12, 16'h0, 1'b0);
    tick();
    check("ld12_cur_delay", 64'(if0.cur_delay), 64'h8);
    for (int t = 1; t <= 10; t++) begin
      if (t == 1) drive0(1'b1, 1'b0, 4'd0, 16'h5A5A, 1'b1);
      else        drive0(1'b1, 1'b0, 4'd0, 16'h0, 1'b0);
      tick();
      check("d8_valid_out", 64'(if0.valid_out), 64'(t == 8));
      check("d8_count",     64'(if0.count),     64'(t <= 8));
      if (t == 8) check("d8_bus_out", 64'(if0.bus_out), 64'h5A5A);
    end

    // Reset together with load mid-stream wins over the load.
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b0, 4'd0, 16'(16'hE000 + i), 1'b1);
      tick();
    end
    reset = 1'b1;
    drive0(1'b1, 1'b1, 4'd4, 16'hE0E0, 1'b1);
    tick();
    check("rl_valid",     64'(if0.valid_out), 64'h0);
    check("rl_count",     64'(if0.count),     64'h0);
    check("rl_cur_delay", 64'(if0.cur_delay), 64'h1);
    check("rl_bus_out",   64'(if0.bus_out),   64'h0);
    reset = 1'b0;
    drive0(1'b1, 1'b0, 4'd0, 16'h1234, 1'b1);
    tick();
    check("rl_post_bus",   64'(if0.bus_out),   64'h1234);
    check("rl_post_valid", 64'(if0.valid_out), 64'h1);
    check("rl_post_count", 64'(if0.count),     64'h1);

    // Packed 4x8 instance at delay 3 with valid_in toggling every cycle.
    if1.en = 1'b1; if1.load = 1'b1; if1.delay_sel = 4'd3; if1.valid_in = 1'b0; if1.bus_in = '0;
    tick();
    check("p_cur_delay", 64'(if1.cur_delay), 64'h3);
    if1.load = 1'b0;
    for (int c = 0; c < 12; c++) begin
      word1.push_back({8'(8'h40 + c), 8'(8'h30 + c), 8'(8'h20 + c), 8'(8'h10 + c)});
      if1.bus_in   = word1[c];
      if1.valid_in = (c % 2 == 0);
      tick();
      if (c >= 2) begin
        check("p_bus_out",   64'(if1.bus_out),   64'(word1[c-2]));
        check("p_valid_out", 64'(if1.valid_out), 64'((c - 2) % 2 == 0));
        check("p_count",     64'(if1.count),     64'((c % 2 == 0) ? 2 : 1));
      end else begin
        check("p_valid_early", 64'(if1.valid_out), 64'h0);
        check("p_count_early", 64'(if1.count),     64'h1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
